// File: rtl/ex_mem_skid_stage.sv
// ex_mem_skid_stage: valid/ready EX/MEM register with one-entry skid buffer and side-state hold channel
module ex_mem_skid_stage #(
  parameter int DATA_W = 128,
  parameter int HOLD_W = 66,
  parameter logic [DATA_W-1:0] NOP_DATA = {DATA_W{1'b0}},
  parameter bit BUBBLE_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  input  logic [HOLD_W-1:0] hold_i,
  output logic [HOLD_W-1:0] hold_o
);
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] main_data;
  logic              acc;
  logic              upd;
  assign in_ready = !skid_valid;
  assign acc      = in_valid & in_ready;
  assign upd      = !out_valid | out_ready;
  assign out_data = (BUBBLE_ZERO && !out_valid) ? NOP_DATA : main_data;
  // Main and skid entries: skid drains first so ordering stays FIFO; flush kills both
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      main_data  <= NOP_DATA;
      skid_valid <= 1'b0;
      skid_data  <= NOP_DATA;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (upd) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          main_data  <= skid_data;
          skid_valid <= 1'b0;
        end else if (acc) begin
          out_valid <= 1'b1;
          main_data <= in_data;
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (acc && out_valid && !out_ready) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end
  end
  // Side state: a newly accepted instruction restarts the accumulator, otherwise it loops back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_o <= '0;
    else     hold_o <= (acc && !flush) ? '0 : hold_i;
  end
endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// tb_ex_mem_skid_stage: scoreboard bench for the skid stage
module tb_ex_mem_skid_stage;
  localparam int DW = 128;
  localparam int HW = 66;
  localparam logic [DW-1:0] NOP = 128'hDEAD_BEEF;
  localparam logic [HW-1:0] H   = 66'h1_0000_0000_0000_0002;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, out_ready = 1'b0, flush = 1'b0;
  logic [DW-1:0] out_data;
  logic [HW-1:0] hold_i = '0, hold_o;
  logic          in_ready1, out_valid1;
  logic [DW-1:0] out_data1;
  logic [HW-1:0] hold_o1;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  ex_mem_skid_stage #(.DATA_W(DW), .HOLD_W(HW), .NOP_DATA(NOP), .BUBBLE_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .flush(flush),
    .hold_i(hold_i), .hold_o(hold_o));

  ex_mem_skid_stage #(.DATA_W(DW), .HOLD_W(HW), .BUBBLE_ZERO(1'b0)) dut_keep (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready), .flush(flush),
    .hold_i(hold_i), .hold_o(hold_o1));

  // Scoreboard: push on accept, pop and compare on drain, drop everything on flush/reset
  always @(posedge clk or posedge rst) begin
    if (rst) sb.delete();
    else if (flush) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_drain: got %h, required nothing (queue empty)", out_data);
        end else begin
          logic [DW-1:0] e;
          e = sb.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL sb_order: got %h, required %h", out_data, e);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
    checks++; if (out_data !== NOP) begin errors++; $display("FAIL rst_data: got %h, required %h", out_data, NOP); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, required 1", in_ready); end
    checks++; if (hold_o !== '0) begin errors++; $display("FAIL rst_hold: got %h, required 0", hold_o); end
    rst = 1'b0;
  endtask

  task automatic test_streaming;
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      logic [DW-1:0] v;
      v = DW'(8'h11 * i);
      in_valid = 1'b1; in_data = v; hold_i = H;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid%0d: got %b, required 1", i, out_valid); end
      checks++; if (out_data !== v) begin errors++; $display("FAIL stream_data%0d: got %h, required %h", i, out_data, v); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d: got %b, required 1", i, in_ready); end
      checks++; if (hold_o !== '0) begin errors++; $display("FAIL stream_hold%0d: got %h, required 0", i, hold_o); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end: got %b, required 0", out_valid); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 'hA;
    @(negedge clk);
    chk("bp_main_a", out_data, 'hA);
    out_ready = 1'b0; in_data = 'hB;
    @(negedge clk);
    chk("bp_hold_a", out_data, 'hA);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b, required 0", in_ready); end
    in_data = 'hC;
    @(negedge clk);
    chk("bp_still_a", out_data, 'hA);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low2: got %b, required 0", in_ready); end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_main_b", out_data, 'hB);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_high: got %b, required 1", in_ready); end
    @(negedge clk);
    chk("bp_main_c", out_data, 'hC);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_end: got %b, required 0", out_valid); end
  endtask

  task automatic test_bubble;
    out_ready = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bub_valid%0d: got %b, required 0", i, out_valid); end
      chk("bub_nop", out_data, NOP);
      chk("bub_keep", out_data1, 'hC);
    end
  endtask

  task automatic test_flush;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 'h5;
    @(negedge clk);
    in_data = 'h6;
    @(negedge clk);
    chk("fl_main5", out_data, 'h5);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_skid_full: got %b, required 0", in_ready); end
    flush = 1'b1; in_data = 'h7;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b, required 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl_ready: got %b, required 1", in_ready); end
    chk("fl_nop", out_data, NOP);
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_after: got %b, required 0", out_valid); end
    flush = 1'b1; in_valid = 1'b1; in_data = 'h8; hold_i = H;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_discard: got %b, required 0", out_valid); end
    checks++; if (hold_o !== H) begin errors++; $display("FAIL fl_hold: got %h, required %h", hold_o, H); end
  endtask

  task automatic test_hold;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 'hD; hold_i = '1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (hold_o !== '0) begin errors++; $display("FAIL hold_acc0: got %h, required 0", hold_o); end
    for (int i = 0; i < 3; i++) begin
      logic [HW-1:0] h;
      h = H + HW'(i);
      hold_i = h;
      @(negedge clk);
      checks++; if (hold_o !== h) begin errors++; $display("FAIL hold_track%0d: got %h, required %h", i, hold_o, h); end
      chk("hold_stall", out_data, 'hD);
    end
    in_valid = 1'b1; in_data = 'hE;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (hold_o !== '0) begin errors++; $display("FAIL hold_acc1: got %h, required 0", hold_o); end
  endtask

  task automatic test_async_reset;
    hold_i = H;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ar_pre_ready: got %b, required 0", in_ready); end
    checks++; if (hold_o !== H) begin errors++; $display("FAIL ar_pre_hold: got %h, required %h", hold_o, H); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b, required 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_ready: got %b, required 1", in_ready); end
    checks++; if (hold_o !== '0) begin errors++; $display("FAIL ar_hold: got %h, required 0", hold_o); end
    chk("ar_nop", out_data, NOP);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_after: got %b, required 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_hold();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d items, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
